// File: rtl/resp_signature_collector.sv
// -----------------------------------------------------------------------------
// resp_signature_collector
//
// Collects the output_data samples of the combinational DUT over a
// valid/ready handshake. Samples are buffered in a small FIFO and then
// compacted by a 16-bit MISR into one signature. The run length is
// programmable. Once the run completes, the signature and sample count hold
// their values until the next start.
//
// Ports
//   clk          in   1       clock, rising edge
//   rst_n        in   1       asynchronous active-low reset
//   start        in   1       begin a run (honoured in IDLE or DONE only)
//   clear        in   1       synchronous abort to IDLE, flushes the FIFO
//   num_samples  in   CNT_W   run length, captured on start
//   hold         in   1       stall MISR compaction (the FIFO keeps filling)
//   in_valid     in   1       upstream sample valid
//   in_data      in   DATA_W  upstream sample
//   in_ready     out  1       a sample can be accepted this cycle
//   busy         out  1       run in progress (COLLECT)
//   done         out  1       run complete (DONE, level)
//   signature    out  16      current MISR value
//   sample_count out  CNT_W   samples compacted so far in this run
//   unexpected   out  1       sticky flag: in_valid seen outside COLLECT
// -----------------------------------------------------------------------------
module resp_signature_collector #(
  parameter int          DATA_W = 9,
  parameter int          DEPTH  = 4,
  parameter int          CNT_W  = 16,
  parameter logic [15:0] POLY   = 16'h1021,
  parameter logic [15:0] SEED   = 16'h0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              clear,
  input  logic [CNT_W-1:0]  num_samples,
  input  logic              hold,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              busy,
  output logic              done,
  output logic [15:0]       signature,
  output logic [CNT_W-1:0]  sample_count,
  output logic              unexpected
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_next;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW:0]       r_wptr;
  logic [AW:0]       r_rptr;
  logic [15:0]       r_sig;
  logic [CNT_W-1:0]  r_scount;
  logic [CNT_W-1:0]  r_acount;
  logic [CNT_W-1:0]  r_num;
  logic              r_unexp;

  logic              w_full;
  logic              w_empty;
  logic              w_collect;
  logic              w_idle_or_done;
  logic              w_push;
  logic              w_pop;
  logic              w_last_pop;
  logic [DATA_W-1:0] w_head;

  // One MISR step: shift left, fold in the polynomial when the MSB falls out,
  // then XOR in the zero-extended sample.
  function automatic logic [15:0] misr_step(input logic [15:0]       sig,
                                            input logic [DATA_W-1:0] smp);
    logic [15:0] fb;
    fb = sig[15] ? POLY : 16'h0000;
    return {sig[14:0], 1'b0} ^ fb ^ 16'(smp);
  endfunction

  // Pointers carry one extra wrap bit: equal addresses with differing wrap
  // bits means full, fully equal pointers means empty.
  assign w_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_empty = (r_wptr == r_rptr);
  assign w_head  = r_mem[r_rptr[AW-1:0]];

  assign w_collect      = (r_state == S_COLLECT);
  assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);

  // in_ready depends only on registered state so upstream never sees a
  // combinational path from its own in_valid. Using full (not full-after-pop)
  // means a push is refused on a full cycle even if a pop also happens.
  assign in_ready   = w_collect && !w_full && (r_acount < r_num);
  assign w_push     = in_valid && in_ready;
  assign w_pop      = w_collect && !w_empty && !hold;
  assign w_last_pop = w_pop && ((r_scount + CNT_W'(1)) == r_num);

  assign busy         = w_collect;
  assign done         = (r_state == S_DONE);
  assign signature    = r_sig;
  assign sample_count = r_scount;
  assign unexpected   = r_unexp;

  // ---- state register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (clear) begin
      w_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE, S_DONE: begin
          if (start) w_next = (num_samples == '0) ? S_DONE : S_COLLECT;
        end
        S_COLLECT: begin
          if (w_last_pop) w_next = S_DONE;
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  // ---- FIFO storage (data only, no reset needed) ----
  always_ff @(posedge clk) begin
    if (w_push && !clear) r_mem[r_wptr[AW-1:0]] <= in_data;
  end

  // ---- pointers, counters and MISR ----
  // clear only flushes the FIFO; signature and counts stay for readback.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_sig    <= '0;
      r_scount <= '0;
      r_acount <= '0;
      r_num    <= '0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else if (w_idle_or_done) begin
      if (start) begin
        r_wptr   <= '0;
        r_rptr   <= '0;
        r_sig    <= SEED;
        r_scount <= '0;
        r_acount <= '0;
        r_num    <= num_samples;
      end
    end else if (w_collect) begin
      if (w_push) begin
        r_wptr   <= r_wptr + 1'b1;
        r_acount <= r_acount + CNT_W'(1);
      end
      if (w_pop) begin
        r_rptr   <= r_rptr + 1'b1;
        r_sig    <= misr_step(r_sig, w_head);
        r_scount <= r_scount + CNT_W'(1);
      end
    end
  end

  // ---- sticky protocol flag ----
  // A start that is actually honoured clears the flag; that takes precedence
  // over an in_valid seen in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_unexp <= 1'b0;
    end else if (start && !clear && w_idle_or_done) begin
      r_unexp <= 1'b0;
    end else if (in_valid && !w_collect) begin
      r_unexp <= 1'b1;
    end
  end

endmodule

// File: tb/tb_resp_signature_collector.sv
module tb_resp_signature_collector;

  logic        clk = 1'b0;
  logic        rst_n, start, clear, hold, in_valid;
  logic [15:0] num_samples;
  logic [8:0]  in_data;

  logic        in_ready0, busy0, done0, unexp0;
  logic [15:0] signature0, sample_count0;
  logic        in_ready1, busy1, done1, unexp1;
  logic [15:0] signature1, sample_count1;

  int          n_vec = 0;
  int          n_err = 0;
  int          hs_cnt;
  logic [15:0] prev_cnt;
  logic [15:0] m0, m1;
  logic [8:0]  q[$];

  always #5 clk = ~clk;

  // Zero seed instance
  resp_signature_collector #(.SEED(16'h0000)) u0 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .num_samples(num_samples), .hold(hold), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready0), .busy(busy0), .done(done0), .signature(signature0),
    .sample_count(sample_count0), .unexpected(unexp0));

  // Non-zero seed instance, driven identically
  resp_signature_collector #(.SEED(16'h8000)) u1 (
    .clk(clk), .rst_n(rst_n), .start(start), .clear(clear),
    .num_samples(num_samples), .hold(hold), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready1), .busy(busy1), .done(done1), .signature(signature1),
    .sample_count(sample_count1), .unexpected(unexp1));

  function automatic logic [15:0] misr_model(input logic [15:0] s, input logic [8:0] d);
    logic [15:0] r;
    r = {s[14:0], 1'b0};
    if (s[15]) r = r ^ 16'h1021;
    return r ^ {7'b0, d};
  endfunction

  // One clock: accepted samples enter the scoreboard queue, each compaction
  // (sample_count step) pops the oldest one and checks both signatures.
  task automatic tick();
    logic       hs;
    logic [8:0] d;
    logic [8:0] s;
    hs = in_valid && in_ready0;
    d  = in_data;
    @(posedge clk); #1;
    if (sample_count0 == prev_cnt + 16'd1) begin
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL sb_pop: compaction with no accepted sample, count=%0d", sample_count0);
      end else begin
        s  = q.pop_front();
        m0 = misr_model(m0, s);
        m1 = misr_model(m1, s);
        if (signature0 !== m0 || signature1 !== m1 || sample_count1 !== sample_count0) begin
          n_err++;
          $display("FAIL sb_sig: got %h/%h expected %h/%h", signature0, signature1, m0, m1);
        end
      end
      prev_cnt = sample_count0;
    end else if (sample_count0 !== prev_cnt) begin
      n_vec++; n_err++;
      $display("FAIL sb_count: got %0d expected %0d or %0d", sample_count0, prev_cnt, prev_cnt + 16'd1);
      prev_cnt = sample_count0;
    end
    if (hs) begin
      q.push_back(d);
      hs_cnt++;
    end
  endtask

  task automatic do_start(input logic [15:0] n);
    start = 1'b1; num_samples = n;
    @(posedge clk); #1;
    start = 1'b0;
    q.delete();
    m0 = 16'h0000; m1 = 16'h8000; prev_cnt = 16'd0; hs_cnt = 0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; clear = 0; hold = 0; in_valid = 0; in_data = '0; num_samples = '0;
    repeat (2) @(posedge clk); #1;
    n_vec++;
    if ({in_ready0, busy0, done0, unexp0, signature0, sample_count0, signature1} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: rdy=%b busy=%b done=%b unexp=%b sig=%h/%h cnt=%0d expected all zero",
               in_ready0, busy0, done0, unexp0, signature0, signature1, sample_count0);
    end
    rst_n = 1'b1;
    prev_cnt = 16'd0; q.delete();
    tick();
  endtask

  task automatic test_single();
    do_start(16'd1);
    n_vec++;
    if (busy0 !== 1'b1 || in_ready0 !== 1'b1) begin
      n_err++; $display("FAIL t1_busy: busy=%b rdy=%b expected 1/1", busy0, in_ready0);
    end
    in_valid = 1'b1; in_data = 9'h1A5;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (done0 !== 1'b0) begin n_err++; $display("FAIL t1_early_done: done=%b expected 0", done0); end
    tick();
    n_vec++;
    if (done0 !== 1'b1 || signature0 !== 16'h01A5 || sample_count0 !== 16'd1) begin
      n_err++;
      $display("FAIL t1_result: done=%b sig=%h cnt=%0d expected 1 01a5 1", done0, signature0, sample_count0);
    end
  endtask

  task automatic test_two_samples();
    do_start(16'd2);
    in_valid = 1'b1; in_data = 9'h001;
    tick();
    in_data = 9'h002;
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (signature0 !== 16'h0000 || sample_count0 !== 16'd2 || done0 !== 1'b1) begin
      n_err++;
      $display("FAIL t2_result: sig=%h cnt=%0d done=%b expected 0000 2 1", signature0, sample_count0, done0);
    end
  endtask

  task automatic test_feedback();
    do_start(16'd1);
    in_valid = 1'b1; in_data = 9'h000;
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (signature1 !== 16'h1021 || signature0 !== 16'h0000) begin
      n_err++;
      $display("FAIL t3_feedback: sig=%h/%h expected 0000/1021", signature0, signature1);
    end
  endtask

  task automatic test_hold_backpressure();
    int k;
    do_start(16'd6);
    hold = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 8; i++) begin
      in_data = 9'($urandom_range(0, 511));
      tick();
    end
    n_vec++;
    if (hs_cnt !== 4 || in_ready0 !== 1'b0 || sample_count0 !== 16'd0) begin
      n_err++;
      $display("FAIL t4_full: accepted=%0d rdy=%b cnt=%0d expected 4 0 0", hs_cnt, in_ready0, sample_count0);
    end
    hold = 1'b0;
    k = 0;
    while (done0 !== 1'b1 && k < 30) begin
      in_data = 9'($urandom_range(0, 511));
      tick();
      if (hs_cnt >= 6) in_valid = 1'b0;
      k++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (done0 !== 1'b1 || hs_cnt !== 6 || sample_count0 !== 16'd6 || signature0 !== m0 || unexp0 !== 1'b0) begin
      n_err++;
      $display("FAIL t4_release: done=%b accepted=%0d cnt=%0d sig=%h expected 1 6 6 %h unexp=%b",
               done0, hs_cnt, sample_count0, signature0, m0, unexp0);
    end
  endtask

  task automatic test_zero_length();
    do_start(16'd0);
    n_vec++;
    if (done0 !== 1'b1 || busy0 !== 1'b0 || signature0 !== 16'h0000 || signature1 !== 16'h8000 || in_ready0 !== 1'b0) begin
      n_err++;
      $display("FAIL t5_zero: done=%b busy=%b sig=%h/%h rdy=%b expected 1 0 0000/8000 0",
               done0, busy0, signature0, signature1, in_ready0);
    end
    tick();
    n_vec++;
    if (in_ready0 !== 1'b0 || done0 !== 1'b1) begin
      n_err++; $display("FAIL t5_hold: rdy=%b done=%b expected 0 1", in_ready0, done0);
    end
  endtask

  task automatic test_clear();
    do_start(16'd3);
    in_valid = 1'b1; in_data = 9'h0C3;
    tick();
    in_valid = 1'b0;
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_vec++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || signature0 !== m0 || sample_count0 !== 16'd1) begin
      n_err++;
      $display("FAIL clear_retain: busy=%b done=%b sig=%h cnt=%0d expected 0 0 %h 1",
               busy0, done0, signature0, sample_count0, m0);
    end
  endtask

  task automatic test_unexpected();
    in_valid = 1'b1; in_data = 9'h055;
    tick();
    in_valid = 1'b0;
    n_vec++;
    if (unexp0 !== 1'b1) begin n_err++; $display("FAIL unexp_set: got %b expected 1", unexp0); end
    tick();
    n_vec++;
    if (unexp0 !== 1'b1) begin n_err++; $display("FAIL unexp_sticky: got %b expected 1", unexp0); end
    do_start(16'd2);
    n_vec++;
    if (unexp0 !== 1'b0) begin n_err++; $display("FAIL unexp_clear: got %b expected 0", unexp0); end
  endtask

  task automatic test_async_reset();
    in_valid = 1'b1; in_data = 9'h1FF;
    tick();
    in_valid = 1'b0;
    tick();
    n_vec++;
    if (busy0 !== 1'b1 || signature0 === 16'h0000) begin
      n_err++; $display("FAIL t6_pre: busy=%b sig=%h expected busy and non-zero sig", busy0, signature0);
    end
    #3 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({in_ready0, busy0, done0, unexp0, signature0, sample_count0, signature1, sample_count1} !== '0) begin
      n_err++;
      $display("FAIL t6_async: rdy=%b busy=%b done=%b unexp=%b sig=%h/%h cnt=%0d expected all zero",
               in_ready0, busy0, done0, unexp0, signature0, signature1, sample_count0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    prev_cnt = 16'd0; q.delete();
    tick();
    n_vec++;
    if (busy0 !== 1'b0 || done0 !== 1'b0 || in_ready0 !== 1'b0) begin
      n_err++; $display("FAIL t6_after: busy=%b done=%b rdy=%b expected 0 0 0", busy0, done0, in_ready0);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_samples();
    test_feedback();
    test_hold_backpressure();
    test_zero_length();
    test_clear();
    test_unexpected();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Absolute time limit so the run always ends on its own.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, vectors=%0d", n_vec);
    $fatal(1);
  end

endmodule
